pwm_core: RTL and testbench

PWM generator datapath fed by the AXI4-Lite register slave of my_pwm_ip. It consumes the decoded register fields (control, prescale, period, duty) and drives the pwm pin. New register values are held as pending and applied only at a period boundary, so the output never glitches. It also returns a live counter value and status for register readback.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_prescaler.sv | 30 +++
 rtl/pwm_core.sv | 162 ++++++++++++++++
 tb/tb_pwm_core.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// PWM core shared types and constants.
// Holds FSM states, ctrl register bit indices and default widths.
package pwm_pkg;

  localparam int CNT_W_DEF    = 32;
  localparam int PRESC_W_DEF  = 16;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_POL_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..prescale, tick on the terminal count.
// Ports: clk, rst, en, clr, prescale in; tick out.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;

  assign tick = en && (presc_cnt == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (clr) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_core.sv
// PWM datapath: shadowed config applied at period wrap, registered pin.
// Ports: ACLK, ARESET, cfg_* in; pwm_out, period_tick, cnt_value,
// update_pending out; irq/irq_clear only when PWM_IRQ_EN is defined.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               cfg_enable,
  input  logic               cfg_polarity,
  input  logic [PRESC_W-1:0] cfg_prescale,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_duty,
  input  logic               cfg_update,
  output logic               pwm_out,
  output logic               period_tick,
  output logic [CNT_W-1:0]   cnt_value,
  output logic               update_pending
`ifdef PWM_IRQ_EN
  ,
  output logic               irq,
  input  logic               irq_clear
`endif
);

  pwm_state_t state, state_d;

  logic               load_start;
  logic               stop;
  logic               run;
  logic               tick;
  logic               wrap;
  logic               reload;

  logic               sh_pol;
  logic [PRESC_W-1:0] sh_presc;
  logic [CNT_W-1:0]   sh_period;
  logic [CNT_W-1:0]   sh_duty;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    load_start = 1'b0;
    stop       = 1'b0;
    run        = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_enable) begin
          state_d    = RUN;
          load_start = 1'b1;
        end
      end
      RUN: begin
        if (!cfg_enable) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else begin
          run = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk      (ACLK),
    .rst      (ARESET),
    .en       (run),
    .clr      (!run),
    .prescale (sh_presc),
    .tick     (tick)
  );

  assign wrap = tick && (cnt == sh_period);

  // A write landing on the wrap cycle is taken at that same wrap.
  assign reload = load_start ||
                  (wrap && (update_pending || cfg_update));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sh_pol    <= 1'b0;
      sh_presc  <= '0;
      sh_period <= '0;
      sh_duty   <= '0;
    end else if (reload) begin
      sh_pol    <= cfg_polarity;
      sh_presc  <= cfg_prescale;
      sh_period <= cfg_period;
      sh_duty   <= cfg_duty;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt <= '0;
    end else if (load_start || stop) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      update_pending <= 1'b0;
    end else if (reload || stop) begin
      update_pending <= 1'b0;
    end else if (cfg_update) begin
      update_pending <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
    end
  end

  // Outside RUN the pin sits at the inactive level.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pwm_out <= 1'b0;
    end else if (run) begin
      pwm_out <= (cnt < sh_duty) ^ sh_pol;
    end else if (load_start) begin
      pwm_out <= cfg_polarity;
    end else begin
      pwm_out <= sh_pol;
    end
  end

  assign cnt_value = cnt;

`ifdef PWM_IRQ_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq <= 1'b0;
    end else if (period_tick) begin
      irq <= 1'b1;
    end else if (irq_clear) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_core.sv
// Self-checking bench for pwm_core.
// Reference model tracks clock position within a period arithmetically.
module tb_pwm_core;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cfg_enable = 1'b0;
  logic        cfg_polarity = 1'b0;
  logic [15:0] cfg_prescale = '0;
  logic [31:0] cfg_period = '0;
  logic [31:0] cfg_duty = '0;
  logic        cfg_update = 1'b0;
  logic        pwm_out;
  logic        period_tick;
  logic [31:0] cnt_value;
  logic        update_pending;
`ifdef PWM_IRQ_EN
  logic        irq;
  logic        irq_clear = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  bit     m_run, m_pend, m_tick, m_pwm, m_irq, m_pol;
  longint m_presc, m_per, m_duty, m_pos;

  pwm_core #(.CNT_W(32), .PRESC_W(16)) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .cfg_enable     (cfg_enable),
    .cfg_polarity   (cfg_polarity),
    .cfg_prescale   (cfg_prescale),
    .cfg_period     (cfg_period),
    .cfg_duty       (cfg_duty),
    .cfg_update     (cfg_update),
    .pwm_out        (pwm_out),
    .period_tick    (period_tick),
    .cnt_value      (cnt_value),
    .update_pending (update_pending)
`ifdef PWM_IRQ_EN
    ,
    .irq            (irq),
    .irq_clear      (irq_clear)
`endif
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_cnt();
    if (!m_run) return 32'd0;
    return 32'(m_pos / (m_presc + 1));
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_tick = 0; m_pwm = 0; m_irq = 0;
    m_pol = 0; m_presc = 0; m_per = 0; m_duty = 0; m_pos = 0;
  endtask

  task automatic model_load();
    m_pol   = cfg_polarity;
    m_presc = cfg_prescale;
    m_per   = cfg_period;
    m_duty  = cfg_duty;
  endtask

  // One clock: advance the model from the inputs seen at the edge.
  task automatic step();
    bit     t_prev;
    longint dv;
    @(posedge ACLK);
    t_prev = m_tick;
    if (ARESET) begin
      model_reset();
    end else begin
      m_tick = 0;
      if (!m_run) begin
        if (cfg_enable) begin
          model_load();
          m_pos = 0; m_run = 1; m_pend = 0; m_pwm = cfg_polarity;
        end else begin
          if (cfg_update) m_pend = 1;
          m_pwm = m_pol;
        end
      end else if (!cfg_enable) begin
        m_run = 0; m_pos = 0; m_pend = 0; m_pwm = m_pol;
      end else begin
        dv = m_presc + 1;
        m_pwm = ((m_pos / dv) < m_duty) ^ m_pol;
        if (m_pos == dv * (m_per + 1) - 1) begin
          m_pos = 0;
          m_tick = 1;
          if (m_pend || cfg_update) begin
            model_load();
            m_pend = 0;
          end
        end else begin
          m_pos++;
          if (cfg_update) m_pend = 1;
        end
      end
`ifdef PWM_IRQ_EN
      m_irq = t_prev | (m_irq & !irq_clear);
`else
      m_irq = t_prev & 1'b0;
`endif
    end
    #1;
  endtask

  task automatic idle(int n);
    cfg_enable = 0;
    repeat (n) step();
  endtask

  task automatic setup(int presc, int per, int duty, bit pol);
    cfg_prescale = 16'(presc);
    cfg_period   = 32'(per);
    cfg_duty     = 32'(duty);
    cfg_polarity = pol;
  endtask

  task automatic test_reset();
    #12;
    if ({pwm_out, period_tick, update_pending} !== 3'b000 ||
        cnt_value !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold got pwm=%b tick=%b pend=%b cnt=%0d want 0 0 0 0",
               pwm_out, period_tick, update_pending, cnt_value);
    end
    checks++;
    model_reset();
    @(negedge ACLK);
    ARESET = 0;
    repeat (3) begin
      step();
      if (pwm_out !== m_pwm || period_tick !== m_tick ||
          update_pending !== m_pend || cnt_value !== exp_cnt()) begin
        failures++;
        $display("FAIL reset_idle got %b %b %b %0d want %b %b %b %0d",
                 pwm_out, period_tick, update_pending, cnt_value,
                 m_pwm, m_tick, m_pend, exp_cnt());
      end
      checks++;
    end
  endtask

  task automatic test_basic();
    int highs = 0;
    int ticks = 0;
    setup(0, 9, 3, 0);
    cfg_enable = 1;
    for (int i = 0; i < 33; i++) begin
      step();
      if (pwm_out !== m_pwm || period_tick !== m_tick ||
          update_pending !== m_pend || cnt_value !== exp_cnt()) begin
        failures++;
        $display("FAIL basic got %b %b %b %0d want %b %b %b %0d",
                 pwm_out, period_tick, update_pending, cnt_value,
                 m_pwm, m_tick, m_pend, exp_cnt());
      end
      checks++;
      if (i >= 3) begin
        highs += int'(pwm_out);
        ticks += int'(period_tick);
      end
    end
    if (highs !== 9 || ticks !== 3) begin
      failures++;
      $display("FAIL basic_shape got highs=%0d ticks=%0d want 9 3",
               highs, ticks);
    end
    checks++;
  endtask

  task automatic test_prescaler();
    int highs = 0;
    int ticks = 0;
    int steps = 0;
    logic [31:0] prev;
    idle(2);
    setup(1, 3, 2, 0);
    cfg_enable = 1;
    for (int i = 0; i < 20; i++) begin
      prev = cnt_value;
      step();
      if (pwm_out !== m_pwm || period_tick !== m_tick ||
          update_pending !== m_pend || cnt_value !== exp_cnt()) begin
        failures++;
        $display("FAIL presc got %b %b %b %0d want %b %b %b %0d",
                 pwm_out, period_tick, update_pending, cnt_value,
                 m_pwm, m_tick, m_pend, exp_cnt());
      end
      checks++;
      if (i >= 4) begin
        highs += int'(pwm_out);
        ticks += int'(period_tick);
        steps += int'(cnt_value != prev);
      end
    end
    if (highs !== 8 || ticks !== 2 || steps !== 8) begin
      failures++;
      $display("FAIL presc_shape got highs=%0d ticks=%0d steps=%0d want 8 2 8",
               highs, ticks, steps);
    end
    checks++;
  endtask

  task automatic test_update();
    int highs;
    bit found;
    idle(2);
    setup(0, 9, 3, 0);
    cfg_enable = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (pwm_out !== m_pwm || cnt_value !== exp_cnt()) begin
        failures++;
        $display("FAIL upd_start got pwm=%b cnt=%0d want %b %0d",
                 pwm_out, cnt_value, m_pwm, exp_cnt());
      end
      checks++;
      found = (cnt_value == 32'd5);
    end
    if (!found) begin
      failures++;
      $display("FAIL upd_wait5 got cnt=%0d want 5", cnt_value);
    end
    checks++;
    cfg_duty = 32'd7;
    cfg_update = 1;
    step();
    cfg_update = 0;
    if (update_pending !== 1'b1) begin
      failures++;
      $display("FAIL upd_pending got %b want 1", update_pending);
    end
    checks++;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (pwm_out !== m_pwm || period_tick !== m_tick ||
          update_pending !== m_pend || cnt_value !== exp_cnt()) begin
        failures++;
        $display("FAIL upd_hold got %b %b %b %0d want %b %b %b %0d",
                 pwm_out, period_tick, update_pending, cnt_value,
                 m_pwm, m_tick, m_pend, exp_cnt());
      end
      checks++;
      found = period_tick;
    end
    if (!found || update_pending !== 1'b0) begin
      failures++;
      $display("FAIL upd_wrap got tick=%b pend=%b want 1 0",
               found, update_pending);
    end
    checks++;
    highs = 0;
    repeat (10) begin
      step();
      highs += int'(pwm_out);
    end
    if (highs !== 7) begin
      failures++;
      $display("FAIL upd_newduty got highs=%0d want 7", highs);
    end
    checks++;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      found = (cnt_value == 32'd9);
      if (!found) step();
    end
    cfg_duty = 32'd2;
    cfg_update = 1;
    step();
    cfg_update = 0;
    if (!found || period_tick !== 1'b1 || update_pending !== 1'b0) begin
      failures++;
      $display("FAIL upd_coinc got tick=%b pend=%b want 1 0",
               period_tick, update_pending);
    end
    checks++;
    highs = 0;
    repeat (10) begin
      step();
      highs += int'(pwm_out);
    end
    if (highs !== 2) begin
      failures++;
      $display("FAIL upd_coinc_duty got highs=%0d want 2", highs);
    end
    checks++;
  endtask

  task automatic test_boundaries();
    int per[3]   = '{9, 9, 0};
    int duty[3]  = '{0, 15, 1};
    int ehigh[3] = '{0, 20, 20};
    int eticks[3] = '{2, 2, 20};
    for (int k = 0; k < 3; k++) begin
      int highs = 0;
      int ticks = 0;
      idle(2);
      setup(0, per[k], duty[k], 0);
      cfg_enable = 1;
      for (int i = 0; i < 23; i++) begin
        step();
        if (pwm_out !== m_pwm || period_tick !== m_tick ||
            cnt_value !== exp_cnt()) begin
          failures++;
          $display("FAIL bound%0d got %b %b %0d want %b %b %0d", k,
                   pwm_out, period_tick, cnt_value,
                   m_pwm, m_tick, exp_cnt());
        end
        checks++;
        if (i >= 3) begin
          highs += int'(pwm_out);
          ticks += int'(period_tick);
        end
      end
      if (highs !== ehigh[k] || ticks !== eticks[k]) begin
        failures++;
        $display("FAIL bound%0d_shape got highs=%0d ticks=%0d want %0d %0d",
                 k, highs, ticks, ehigh[k], eticks[k]);
      end
      checks++;
    end
  endtask

  task automatic test_polarity_enable();
    int highs = 0;
    bit found = 0;
    idle(2);
    setup(0, 9, 3, 1);
    cfg_enable = 1;
    for (int i = 0; i < 23; i++) begin
      step();
      if (pwm_out !== m_pwm || cnt_value !== exp_cnt()) begin
        failures++;
        $display("FAIL pol got pwm=%b cnt=%0d want %b %0d",
                 pwm_out, cnt_value, m_pwm, exp_cnt());
      end
      checks++;
      if (i >= 3) highs += int'(pwm_out);
    end
    if (highs !== 14) begin
      failures++;
      $display("FAIL pol_shape got highs=%0d want 14", highs);
    end
    checks++;
    for (int i = 0; i < 12 && !found; i++) begin
      found = (cnt_value == 32'd5);
      if (!found) step();
    end
    cfg_enable = 0;
    step();
    if (!found || pwm_out !== 1'b1 || cnt_value !== 32'd0) begin
      failures++;
      $display("FAIL disable got pwm=%b cnt=%0d want 1 0",
               pwm_out, cnt_value);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    idle(2);
    setup(0, 9, 5, 0);
    cfg_enable = 1;
    repeat (7) step();
    cfg_update = 1;
    step();
    cfg_update = 0;
    #2;
    ARESET = 1;
    #1;
    if ({pwm_out, period_tick, update_pending} !== 3'b000 ||
        cnt_value !== 32'd0
`ifdef PWM_IRQ_EN
        || irq !== 1'b0
`endif
       ) begin
      failures++;
      $display("FAIL async_reset got pwm=%b tick=%b pend=%b cnt=%0d want 0 0 0 0",
               pwm_out, period_tick, update_pending, cnt_value);
    end
    checks++;
    model_reset();
    step();
    ARESET = 0;
    repeat (5) begin
      step();
      if (pwm_out !== m_pwm || period_tick !== m_tick ||
          update_pending !== m_pend || cnt_value !== exp_cnt()) begin
        failures++;
        $display("FAIL post_reset got %b %b %b %0d want %b %b %b %0d",
                 pwm_out, period_tick, update_pending, cnt_value,
                 m_pwm, m_tick, m_pend, exp_cnt());
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 3) == 0) begin
        cfg_prescale = 16'($urandom_range(0, 3));
        cfg_period   = 32'($urandom_range(0, 7));
        cfg_duty     = 32'($urandom_range(0, 10));
        cfg_polarity = 1'($urandom_range(0, 1));
      end
      cfg_update = ($urandom_range(0, 5) == 0);
`ifdef PWM_IRQ_EN
      irq_clear = ($urandom_range(0, 7) == 0);
`endif
      step();
      if (pwm_out !== m_pwm || period_tick !== m_tick ||
          update_pending !== m_pend || cnt_value !== exp_cnt()
`ifdef PWM_IRQ_EN
          || irq !== m_irq
`endif
         ) begin
        failures++;
        $display("FAIL random%0d got %b %b %b %0d want %b %b %b %0d", i,
                 pwm_out, period_tick, update_pending, cnt_value,
                 m_pwm, m_tick, m_pend, exp_cnt());
      end
      checks++;
    end
    cfg_update = 0;
`ifdef PWM_IRQ_EN
    irq_clear = 0;
`endif
  endtask

`ifdef PWM_IRQ_EN
  task automatic test_irq();
    bit found = 0;
    idle(2);
    irq_clear = 1;
    step();
    irq_clear = 0;
    setup(0, 3, 1, 0);
    cfg_enable = 1;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL irq_pre got %b want 0", irq);
      end
      checks++;
      found = period_tick;
    end
    repeat (3) begin
      step();
      if (irq !== 1'b1 || irq !== m_irq) begin
        failures++;
        $display("FAIL irq_set got %b want 1", irq);
      end
      checks++;
    end
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      found = period_tick;
      if (!found) step();
    end
    irq_clear = 1;
    step();
    irq_clear = 0;
    if (!found || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_coinc got %b want 1", irq);
    end
    checks++;
    irq_clear = 1;
    step();
    irq_clear = 0;
    if (irq !== 1'b0 || irq !== m_irq) begin
      failures++;
      $display("FAIL irq_clear got %b want 0", irq);
    end
    checks++;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_prescaler();
    test_update();
    test_boundaries();
    test_polarity_enable();
    test_async_reset();
    test_random();
`ifdef PWM_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
